// File: rtl/branch_history_table_if.sv
// rtl/branch_history_table_if.sv - lookup/update/prediction bundle for branch_history_table
//
// Purpose: groups the request and response signals of the branch history table.
// Ports (master = requester, slave = table):
//   lookup_en, lookup_pc                  prediction request
//   update_en, update_pc, update_taken    resolved-branch training
//   pred_valid, pred_taken, pred_cnt      registered prediction response
//   busy                                  table initialisation in progress
interface branch_history_table_if #(
  parameter int CNT_W = 2,
  parameter int PC_W  = 16
) ();
  logic             lookup_en;
  logic [PC_W-1:0]  lookup_pc;
  logic             update_en;
  logic [PC_W-1:0]  update_pc;
  logic             update_taken;
  logic             pred_valid;
  logic             pred_taken;
  logic [CNT_W-1:0] pred_cnt;
  logic             busy;

  modport master (
    output lookup_en, lookup_pc, update_en, update_pc, update_taken,
    input  pred_valid, pred_taken, pred_cnt, busy
  );

  modport slave (
    input  lookup_en, lookup_pc, update_en, update_pc, update_taken,
    output pred_valid, pred_taken, pred_cnt, busy
  );
endinterface

// File: rtl/branch_history_table.sv
// rtl/branch_history_table.sv - saturating-counter branch history table with init sweep
//
// Purpose: 2^IDX_W entries of CNT_W-bit saturating counters. Lookups return the
// indexed counter one cycle later; updates train the counter toward the outcome.
// After reset an INIT sweep writes weak not-taken into every entry, one per cycle.
// Optional macro: BHT_GSHARE_EN - index is pc XOR a global history register.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  branch_history_table_if.slave (lookup, update, prediction, busy)
module branch_history_table #(
  parameter int IDX_W = 4,
  parameter int CNT_W = 2,
  parameter int PC_W  = 16
) (
  input logic                   clk,
  input logic                   rst,
  branch_history_table_if.slave bus
);

  localparam int ENTRIES = 1 << IDX_W;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  // Weak not-taken: MSB clear, all lower bits set.
  localparam logic [CNT_W-1:0] INIT_VAL = {1'b0, {(CNT_W-1){1'b1}}};

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  logic             pred_valid_q, pred_valid_d;
  logic             pred_taken_q, pred_taken_d;
  logic [CNT_W-1:0] pred_cnt_q, pred_cnt_d;

  // Table has no reset; the INIT sweep defines its contents.
  logic [CNT_W-1:0] table_q [ENTRIES];

  logic             busy;
  logic             lookup_acc;
  logic             update_acc;
  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] update_idx;
  logic [CNT_W-1:0] upd_cur;
  logic [CNT_W-1:0] upd_next;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [CNT_W-1:0] wr_val;

  // Upper PC bits do not participate in indexing.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.lookup_pc, bus.update_pc};

`ifdef BHT_GSHARE_EN
  logic [IDX_W-1:0] ghr_q, ghr_d;
`endif

  always_comb begin
    busy       = (state_q == ST_INIT);
    lookup_acc = bus.lookup_en && !busy;
    update_acc = bus.update_en && !busy;

`ifdef BHT_GSHARE_EN
    // Both ports hash with the pre-shift history of this cycle.
    lookup_idx = bus.lookup_pc[IDX_W-1:0] ^ ghr_q;
    update_idx = bus.update_pc[IDX_W-1:0] ^ ghr_q;
    ghr_d      = update_acc ? {ghr_q[IDX_W-2:0], bus.update_taken} : ghr_q;
`else
    lookup_idx = bus.lookup_pc[IDX_W-1:0];
    update_idx = bus.update_pc[IDX_W-1:0];
`endif

    upd_cur = table_q[update_idx];
    if (bus.update_taken) begin
      upd_next = (upd_cur == CNT_MAX) ? upd_cur : upd_cur + 1'b1;
    end else begin
      upd_next = (upd_cur == '0) ? upd_cur : upd_cur - 1'b1;
    end

    // INIT and RUN never write in the same cycle, so one write port suffices.
    if (busy) begin
      wr_en  = 1'b1;
      wr_idx = sweep_q;
      wr_val = INIT_VAL;
    end else begin
      wr_en  = update_acc;
      wr_idx = update_idx;
      wr_val = upd_next;
    end

    sweep_d = busy ? sweep_q + 1'b1 : sweep_q;
    state_d = (busy && (sweep_q == {IDX_W{1'b1}})) ? ST_RUN : state_q;

    // Lookup reads the array before this cycle's write lands: pre-update value.
    pred_valid_d = lookup_acc;
    pred_cnt_d   = lookup_acc ? table_q[lookup_idx] : pred_cnt_q;
    pred_taken_d = lookup_acc ? table_q[lookup_idx][CNT_W-1] : pred_taken_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_INIT;
      sweep_q      <= '0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
      pred_cnt_q   <= pred_cnt_d;
    end
  end

`ifdef BHT_GSHARE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      table_q[wr_idx] <= wr_val;
    end
  end

  assign bus.busy       = busy;
  assign bus.pred_valid = pred_valid_q;
  assign bus.pred_taken = pred_taken_q;
  assign bus.pred_cnt   = pred_cnt_q;

endmodule

// File: tb/tb_branch_history_table.sv
// tb/tb_branch_history_table.sv - scoreboard bench for branch_history_table
module tb_branch_history_table;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  typedef struct {
    logic [1:0] cnt;
    logic       tk;
    int         tag;
  } exp_t;

  exp_t exp_q[$];
  int   tag_n;

  branch_history_table_if #(.CNT_W(2), .PC_W(16)) bus ();

  branch_history_table #(.IDX_W(4), .CNT_W(2), .PC_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Monitor: every presented prediction must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.pred_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pred_valid: got cnt=%0d taken=%0d, required no prediction",
                 bus.pred_cnt, bus.pred_taken);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.pred_cnt !== e.cnt || bus.pred_taken !== e.tk) begin
          bad++;
          $display("FAIL lookup#%0d: got cnt=%0d taken=%0d, required cnt=%0d taken=%0d",
                   e.tag, bus.pred_cnt, bus.pred_taken, e.cnt, e.tk);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic idle();
    bus.lookup_en    = 1'b0;
    bus.lookup_pc    = '0;
    bus.update_en    = 1'b0;
    bus.update_pc    = '0;
    bus.update_taken = 1'b0;
  endtask

  // Issues one lookup (plus any update already driven) for one cycle.
  task automatic lookup(input logic [15:0] pc, input logic [1:0] cnt, input logic tk);
    exp_t e;
    e.cnt = cnt;
    e.tk  = tk;
    e.tag = tag_n;
    tag_n++;
    exp_q.push_back(e);
    bus.lookup_en = 1'b1;
    bus.lookup_pc = pc;
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic update(input logic [15:0] pc, input logic tk);
    bus.update_en    = 1'b1;
    bus.update_pc    = pc;
    bus.update_taken = tk;
    @(posedge clk);
    #1;
    idle();
  endtask

  // Releases reset and counts busy cycles while hammering requests at PC 0x0003.
  task automatic release_and_count(output int n);
    rst = 1'b0;
    bus.lookup_en    = 1'b1;
    bus.lookup_pc    = 16'h0003;
    bus.update_en    = 1'b1;
    bus.update_pc    = 16'h0003;
    bus.update_taken = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.busy !== 1'b1) break;
    end
    idle();
  endtask

  initial begin
    int n;
    total = 0;
    bad   = 0;
    tag_n = 0;
    rst   = 1'b1;
    idle();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 1);
    chk("rst_pred_valid", 32'(bus.pred_valid), 0);
    chk("rst_pred_cnt", 32'(bus.pred_cnt), 0);
    chk("rst_pred_taken", 32'(bus.pred_taken), 0);

    release_and_count(n);
    chk("init_busy_cycles", 32'(n), 16);

`ifdef BHT_GSHARE_EN
    update(16'h0000, 1'b1);              // GHR 0 -> idx 0 = 2, GHR = 1
    update(16'h0000, 1'b1);              // GHR 1 -> idx 1 = 2, GHR = 3
    update(16'h0001, 1'b1);              // GHR 3 -> idx 2 = 2, GHR = 7
    lookup(16'h0001, 2'd1, 1'b0);        // 1^7 = 6, untouched
    lookup(16'h0005, 2'd2, 1'b1);        // 5^7 = 2
    bus.update_en    = 1'b1;             // same cycle: pre-shift GHR 7, idx 2
    bus.update_pc    = 16'h0005;
    bus.update_taken = 1'b0;
    lookup(16'h0005, 2'd2, 1'b1);        // entry 2 -> 1, GHR = 0xE
    lookup(16'h000C, 2'd1, 1'b0);        // C^E = 2
    lookup(16'h0003, 2'd1, 1'b0);        // 3^E = D, busy-time update ignored
`else
    lookup(16'h0003, 2'd1, 1'b0);        // busy-time updates ignored
    lookup(16'hABCD, 2'd1, 1'b0);

    repeat (4) update(16'h0005, 1'b1);
    lookup(16'h0005, 2'd3, 1'b1);
    repeat (5) update(16'h0005, 1'b0);
    lookup(16'h0005, 2'd0, 1'b0);

    bus.update_en    = 1'b1;
    bus.update_pc    = 16'h0007;
    bus.update_taken = 1'b1;
    lookup(16'h0007, 2'd1, 1'b0);
    lookup(16'h0007, 2'd2, 1'b1);

    bus.update_en    = 1'b1;
    bus.update_pc    = 16'h0009;
    bus.update_taken = 1'b1;
    lookup(16'h0008, 2'd1, 1'b0);
    lookup(16'h0009, 2'd2, 1'b1);

    update(16'h0013, 1'b1);
    update(16'h0013, 1'b1);
    lookup(16'h0003, 2'd3, 1'b1);
    @(posedge clk);
    #1;
    chk("hold_pred_valid", 32'(bus.pred_valid), 0);
    chk("hold_pred_cnt", 32'(bus.pred_cnt), 3);
    chk("hold_pred_taken", 32'(bus.pred_taken), 1);
    lookup(16'h0004, 2'd1, 1'b0);

    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst2_pred_cnt", 32'(bus.pred_cnt), 0);
    chk("rst2_busy", 32'(bus.busy), 1);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    release_and_count(n);
    chk("midinit_busy_cycles", 32'(n), 16);
    lookup(16'h0003, 2'd1, 1'b0);
    lookup(16'h0005, 2'd1, 1'b0);
    lookup(16'h0007, 2'd1, 1'b0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_history_table.md
BRANCH_HISTORY_TABLE -- requirements
Module: branch_history_table

Interface
REQ-001 Parameter IDX_W, default 4, index width; the table SHALL hold 2^IDX_W entries.
REQ-002 Parameter CNT_W, default 2, saturating counter width per entry (legal range 2..4).
REQ-003 Parameter PC_W, default 16, width of the PC inputs (PC_W >= IDX_W).
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 lookup_en  input  1  prediction request this cycle.
REQ-007 lookup_pc  input  PC_W  PC of the branch being predicted.
REQ-008 pred_valid  output  1  registered; pred_taken and pred_cnt are valid this cycle.
REQ-009 pred_taken  output  1  registered prediction (1 = taken).
REQ-010 pred_cnt  output  CNT_W  registered raw counter value behind the prediction.
REQ-011 update_en  input  1  resolved-branch training request this cycle.
REQ-012 update_pc  input  PC_W  PC of the resolved branch.
REQ-013 update_taken  input  1  resolved outcome (1 = taken).
REQ-014 busy  output  1  table initialisation in progress; requests are ignored.

Function
REQ-015 Index SHALL be pc[IDX_W-1:0] (XORed with history when GSHARE_EN is defined; see REQ-029).
REQ-016 The entry value encoding SHALL be 0 = strong not-taken, 2^CNT_W-1 = strong taken; prediction = counter MSB.
REQ-017 Accepted update: taken SHALL increment the entry, saturating at 2^CNT_W-1; not-taken SHALL decrement it, saturating at 0.
REQ-018 Accepted lookup: pred_valid, pred_taken and pred_cnt SHALL reflect the indexed entry one cycle after lookup_en (latency 1).
REQ-019 pred_valid SHALL be 0 in any cycle following a cycle without an accepted lookup; pred_taken and pred_cnt SHALL hold their last values.
REQ-020 Lookup and update to the same index in the same cycle: the lookup SHALL return the pre-update value; the update SHALL still be applied.
REQ-021 Lookup and update to different indices in the same cycle SHALL both complete independently.
REQ-022 FSM states INIT and RUN. INIT SHALL write INIT_VAL = 2^(CNT_W-1)-1 (weak not-taken) to one entry per cycle, in ascending index order.
REQ-023 INIT SHALL last exactly 2^IDX_W cycles after rst deasserts, then go to RUN; busy SHALL be 1 in INIT and 0 in RUN.
REQ-024 While busy=1, lookup_en and update_en SHALL be ignored and pred_valid SHALL be 0.

Reset
REQ-025 While rst=1: state SHALL be INIT, sweep pointer 0, busy=1, pred_valid=0, pred_taken=0, pred_cnt=0; no table writes.
REQ-026 Assertion of rst at any time, including mid-INIT, SHALL restart the sweep from index 0 on the first cycle after rst deasserts.
REQ-027 The table contents SHALL NOT be reset directly; the INIT sweep defines them.

Configuration
REQ-028 Macro BHT_GSHARE_EN SHALL select gshare indexing.
REQ-029 With BHT_GSHARE_EN defined: an IDX_W-bit global history register (GHR) SHALL exist; index = pc[IDX_W-1:0] XOR GHR for both lookup and update.
REQ-030 GHR SHALL shift left by one, inserting update_taken at bit 0, on every accepted update; it SHALL be cleared by rst; the lookup in the same cycle SHALL use the pre-shift GHR.
REQ-031 Without BHT_GSHARE_EN: no GHR SHALL be present and the index is pc[IDX_W-1:0] only.

Verification
REQ-032 Reset/init: rst high 3 cycles, then low -> busy=1 for exactly 16 cycles (IDX_W=4); a subsequent lookup of any PC -> pred_cnt=1, pred_taken=0.
REQ-033 Saturation: 4 taken updates to PC 0x0005, then lookup -> pred_cnt=3, pred_taken=1; 5 not-taken updates, then lookup -> pred_cnt=0.
REQ-034 Collision: same-cycle lookup and taken update to PC 0x0007 (entry=1) -> pred_cnt=1 next cycle; a lookup one cycle later -> pred_cnt=2.
REQ-035 Aliasing/isolation: updates to PC 0x0013 affect a lookup of PC 0x0003 (same index) but not one of PC 0x0004.
REQ-036 Reset mid-init: rst pulsed at sweep cycle 8 -> busy stays high for 16 more cycles after release; requests issued during busy produce pred_valid=0 and no table change.
REQ-037 BHT_GSHARE_EN: updates taken, taken (GHR=0x3), then taken update to PC 0x0001 -> entry 0x2 incremented to 2; lookup of PC 0x0001 with GHR=0x7 reads entry 0x6 -> pred_cnt=1.
